// File: rtl/ext_bus_seq_pkg.sv
// ext_bus_seq_pkg: shared types and constants for the external memory-cycle sequencer.
// Revision: 1.0
`default_nettype none

package ext_bus_seq_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int T_STATES = 4;

  localparam logic [DATA_W-1:0] RDATA_RESET = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'(T_STATES),
    ST_TW   = 3'd5
  } bus_state_e;

  // States in which the bus is owned by a machine cycle (strobes may be active).
  function automatic logic is_active(input bus_state_e s);
    return (s == ST_T1) || (s == ST_T2) || (s == ST_T3) || (s == ST_TW);
  endfunction

  // States in which the write strobe and data-out enable are asserted.
  function automatic logic is_write_window(input bus_state_e s);
    return (s == ST_T2) || (s == ST_T3) || (s == ST_TW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_seq_fsm.sv
// bus_seq_fsm: T-state register and next-state logic; optional TW stretch under BUS_WAIT_EN.
// Revision: 1.0
`default_nettype none

module bus_seq_fsm
  import ext_bus_seq_pkg::*;
(
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       i_req,
`ifdef BUS_WAIT_EN
  input  logic       nWAIT,
`endif
  output bus_state_e o_state,
  output logic       o_accept
);

  bus_state_e r_state;
  bus_state_e w_next;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A new request is only accepted from IDLE or the last T-state, so back-to-back
  // cycles chain T4 -> T1 without an idle gap.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_T4: w_next = i_req ? ST_T1 : ST_IDLE;
      ST_T1:          w_next = ST_T2;
`ifdef BUS_WAIT_EN
      ST_T2:          w_next = nWAIT ? ST_T3 : ST_TW;
      ST_TW:          w_next = nWAIT ? ST_T3 : ST_TW;
`else
      ST_T2:          w_next = ST_T3;
`endif
      ST_T3:          w_next = ST_T4;
      default:        w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_state  = r_state;
    o_accept = ((r_state == ST_IDLE) || (r_state == ST_T4)) && i_req;
  end

endmodule

`default_nettype wire

// File: rtl/ext_bus_seq.sv
// ext_bus_seq: four-T-state external memory cycle sequencer with registered pin outputs.
// Optional wait-state support is enabled by defining BUS_WAIT_EN. Revision: 1.0
`default_nettype none

module ext_bus_seq
  import ext_bus_seq_pkg::*;
(
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic              Test1,
  input  logic [DATA_W-1:0] DataBus_in,
`ifdef BUS_WAIT_EN
  input  logic              nWAIT,
`endif
  output logic [ADDR_W-1:0] A,
  output logic              nRD,
  output logic              nWR,
  output logic              DataOut,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              cyc_done
);

  bus_state_e        w_state;
  logic              w_accept;
  logic              w_rd_strobe;
  logic              w_wr_strobe;

  logic [ADDR_W-1:0] r_addr;
  logic              r_is_rd;
  logic [ADDR_W-1:0] r_a;
  logic              r_nrd;
  logic              r_nwr;
  logic              r_dout;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_busy;
  logic              r_cyc_done;

  bus_seq_fsm u_fsm (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .i_req    (req_rd | req_wr),
`ifdef BUS_WAIT_EN
    .nWAIT    (nWAIT),
`endif
    .o_state  (w_state),
    .o_accept (w_accept)
  );

  // Read wins a simultaneous request, so the direction latch only needs req_rd.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_addr  <= '0;
      r_is_rd <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= addr;
      r_is_rd <= req_rd;
    end
  end

  // Test1 gates the strobes every cycle so a mid-cycle change lands on the next edge.
  always_comb begin
    w_rd_strobe = r_is_rd  && !Test1 && is_active(w_state);
    w_wr_strobe = !r_is_rd && !Test1 && is_write_window(w_state);
  end

  // Pins are decoded from the current state and registered, so they trail it by one edge.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_a           <= '0;
      r_nrd         <= 1'b1;
      r_nwr         <= 1'b1;
      r_dout        <= 1'b0;
      r_rdata       <= RDATA_RESET;
      r_rdata_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_cyc_done    <= 1'b0;
    end else begin
      if (w_state == ST_T1) begin
        r_a <= r_addr;
      end
      r_nrd  <= !w_rd_strobe;
      r_nwr  <= !w_wr_strobe;
      r_dout <= w_wr_strobe;
      if ((w_state == ST_T3) && r_is_rd) begin
        r_rdata <= Test1 ? RDATA_RESET : DataBus_in;
      end
      r_rdata_valid <= (w_state == ST_T4) && r_is_rd;
      r_busy        <= is_active(w_state);
      r_cyc_done    <= (w_state == ST_T4);
    end
  end

  assign A           = r_a;
  assign nRD         = r_nrd;
  assign nWR         = r_nwr;
  assign DataOut     = r_dout;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign busy        = r_busy;
  assign cyc_done    = r_cyc_done;

endmodule

`default_nettype wire

// File: tb/tb_ext_bus_seq.sv
// tb_ext_bus_seq: directed and randomized machine cycles checked against a pin-level reference model.
// Revision: 1.0
`default_nettype none

module tb_ext_bus_seq;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        req_rd;
  logic        req_wr;
  logic [15:0] addr;
  logic        Test1;
  logic [7:0]  DataBus_in;
`ifdef BUS_WAIT_EN
  logic        nWAIT = 1'b1;
`endif
  logic [15:0] A;
  logic        nRD;
  logic        nWR;
  logic        DataOut;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        busy;
  logic        cyc_done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: pins that hold between cycles.
  logic [15:0] m_A;
  logic [7:0]  m_rdata;

  always #5 CLK = ~CLK;

  ext_bus_seq dut (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .addr        (addr),
    .Test1       (Test1),
    .DataBus_in  (DataBus_in),
`ifdef BUS_WAIT_EN
    .nWAIT       (nWAIT),
`endif
    .A           (A),
    .nRD         (nRD),
    .nWR         (nWR),
    .DataOut     (DataOut),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .cyc_done    (cyc_done)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pins(input string tag, input logic [15:0] eA, input bit enrd, input bit enwr,
                            input bit edo, input bit ebusy, input bit ecd, input bit erv,
                            input logic [7:0] erd);
    chk({tag, ".A"}, A, eA);
    chk({tag, ".nRD"}, {15'd0, nRD}, {15'd0, enrd});
    chk({tag, ".nWR"}, {15'd0, nWR}, {15'd0, enwr});
    chk({tag, ".DataOut"}, {15'd0, DataOut}, {15'd0, edo});
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, ebusy});
    chk({tag, ".cyc_done"}, {15'd0, cyc_done}, {15'd0, ecd});
    chk({tag, ".rdata_valid"}, {15'd0, rdata_valid}, {15'd0, erv});
    chk({tag, ".rdata"}, {8'd0, rdata}, {8'd0, erd});
  endtask

  // One machine cycle. Pin phase p counts edges after the request edge: strobes for
  // p=1..3, data captured at p=3, done pulse at p=4. 'chained' means the request edge
  // was the previous call's last edge; 'keep' holds the request for a following cycle.
  task automatic xact(input string tag, input bit rd, input bit wr, input logic [15:0] a,
                      input logic [7:0] d, input bit t1, input bit chained, input bit keep);
    bit rd_e;
    bit wr_e;
    bit wwin;
    rd_e = rd;
    wr_e = wr && !rd;
    if (!chained) begin
      @(negedge CLK);
      req_rd = rd; req_wr = wr; addr = a; Test1 = t1; DataBus_in = 8'($urandom);
      @(posedge CLK);
    end
    for (int p = 1; p <= 4; p++) begin
      @(negedge CLK);
      if (!keep) begin
        if (p < 4) begin
          req_rd = 1'($urandom); req_wr = 1'($urandom); addr = 16'($urandom);
        end else begin
          req_rd = 1'b0; req_wr = 1'b0;
        end
      end
      DataBus_in = (p == 3) ? d : 8'($urandom);
      @(posedge CLK); #1;
      if (p == 1) m_A = a;
      if (p == 3 && rd_e) m_rdata = t1 ? 8'hFF : d;
      wwin = wr_e && !t1 && (p == 2 || p == 3);
      check_pins($sformatf("%s.p%0d", tag, p), m_A, !(rd_e && !t1 && p <= 3), !wwin, wwin,
                 p <= 3, p == 4, rd_e && p == 4, m_rdata);
    end
  endtask

  task automatic idle_edge(input string tag);
    @(negedge CLK);
    @(posedge CLK); #1;
    check_pins(tag, m_A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ha;
    bit          r_rd;
    bit          r_wr;
    nRESET = 1'b0; req_rd = 1'b0; req_wr = 1'b0; addr = '0; Test1 = 1'b0; DataBus_in = '0;
    m_A = 16'h0000; m_rdata = 8'hFF;
    repeat (3) @(posedge CLK);
    #1;
    check_pins("reset", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
    @(negedge CLK);
    nRESET = 1'b1;
    idle_edge("idle0");

    xact("rd_C123", 1'b1, 1'b0, 16'hC123, 8'h5A, 1'b0, 1'b0, 1'b0);
    xact("wr_FF80", 1'b0, 1'b1, 16'hFF80, 8'($urandom), 1'b0, 1'b0, 1'b0);

    ha = 16'($urandom);
    xact("hold1", 1'b1, 1'b0, ha, 8'($urandom), 1'b0, 1'b0, 1'b1);
    xact("hold2", 1'b1, 1'b0, ha, 8'($urandom), 1'b0, 1'b1, 1'b1);
    xact("hold3", 1'b1, 1'b0, ha, 8'($urandom), 1'b0, 1'b1, 1'b0);
    idle_edge("idle_after_hold");

    xact("rdwr_0100", 1'b1, 1'b1, 16'h0100, 8'($urandom), 1'b0, 1'b0, 1'b0);
    xact("t1_rd", 1'b1, 1'b0, 16'($urandom), 8'h00, 1'b1, 1'b0, 1'b0);
    xact("t1_wr", 1'b0, 1'b1, 16'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      r_rd = 1'($urandom);
      r_wr = r_rd ? 1'($urandom) : 1'b1;
      xact($sformatf("rnd%0d", i), r_rd, r_wr, 16'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
    end

    // Asynchronous reset while the write strobe is low.
    @(negedge CLK);
    req_rd = 1'b0; req_wr = 1'b1; addr = 16'hA55A; Test1 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    req_wr = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
    chk("rst_pre.nWR", {15'd0, nWR}, 16'd0);
    chk("rst_pre.DataOut", {15'd0, DataOut}, 16'd1);
    #2;
    nRESET = 1'b0;
    #1;
    m_A = 16'h0000; m_rdata = 8'hFF;
    check_pins("rst_async", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
    @(negedge CLK);
    nRESET = 1'b1;
    for (int i = 0; i < 4; i++) idle_edge($sformatf("rst_idle%0d", i));

    xact("post_rst_rd", 1'b1, 1'b0, 16'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);

`ifdef BUS_WAIT_EN
    // nWAIT low for the two samples at end of T2 and in TW stretches the cycle to 6 clocks.
    @(negedge CLK);
    req_rd = 1'b1; req_wr = 1'b0; addr = 16'h1234; Test1 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    req_rd = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nWAIT = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    nWAIT = 1'b1;
    @(posedge CLK); #1;
    m_A = 16'h1234;
    check_pins("wait_p4", m_A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_rdata);
    @(negedge CLK);
    DataBus_in = 8'hC3;
    @(posedge CLK); #1;
    m_rdata = 8'hC3;
    check_pins("wait_p5", m_A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_rdata);
    @(posedge CLK); #1;
    check_pins("wait_p6", m_A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, m_rdata);
`endif

    idle_edge("final_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ext_bus_seq.md
# ext_bus_seq

External memory-cycle sequencer for the SM83 core. It turns one read or write request from the core into a four-T-state machine cycle on the external pins: it drives the address, generates the nRD/nWR strobes and the write-data output enable that feeds the databus mux stage, and captures read data from the external databus. It sits between the core's bus-request logic and the databus mux / pad ring.

## Interface

- No parameters; widths are fixed (16-bit address, 8-bit data).
- CLK  in  1  Core clock (CLK2 domain); one T-state per rising edge.
- nRESET  in  1  Asynchronous, active-low reset.
- req_rd  in  1  Read request, sampled only in IDLE or T4.
- req_wr  in  1  Write request, sampled only in IDLE or T4.
- addr  in  16  Request address, captured with the request.
- Test1  in  1  External test pin; 1 = bus disabled (strobes suppressed).
- DataBus_in  in  8  External databus value (pad input side).
- nWAIT  in  1  External wait, active-low; present only with BUS_WAIT_EN.
- A  out  16  External address pins.
- nRD  out  1  Read strobe, active-low.
- nWR  out  1  Write strobe, active-low.
- DataOut  out  1  Enable for write data onto the external bus (to the mux stage).
- rdata  out  8  Captured read data; holds until the next read capture.
- rdata_valid  out  1  One-cycle pulse in T4 of a read.
- busy  out  1  High in T1–T3 (and TW).
- cyc_done  out  1  One-cycle pulse in T4 of any cycle.

## Operation

- States: IDLE, T1, T2, T3, T4, plus TW with BUS_WAIT_EN. Encoding lives in the package.
- IDLE/T4: if req_rd or req_wr, latch addr and the direction, then go to T1. Otherwise go to (or stay in) IDLE. Back-to-back cycles have no idle gap.
- Simultaneous req_rd and req_wr: read wins and the write is dropped, with no other side effect.
- T1: A takes the latched address. For a read, nRD falls.
- T2: for a write, nWR falls and DataOut rises.
- T3: at the end of T3, a read captures DataBus_in into rdata.
- T4: nRD, nWR and DataOut all return inactive. cyc_done pulses. rdata_valid pulses for reads.
- A holds its last value through IDLE and changes only on entry to T1.
- Test1=1:
  - The sequence runs normally, but nRD, nWR and DataOut are forced inactive.
  - Reads capture 8'hFF.
  - Test1 is sampled every cycle, so a mid-cycle change takes effect on the next edge.

## Timing

- All outputs are registered. Nothing is combinational from inputs to outputs.
- Reset values: A=16'h0000, nRD=1, nWR=1, DataOut=0, rdata=8'hFF, rdata_valid=0, busy=0, cyc_done=0, state=IDLE.
- Latency: a request seen at edge N gives T1 at edge N+1, read data in rdata at edge N+3, and rdata_valid/cyc_done at N+4.
- Throughput: one machine cycle per 4 clocks.
- Requests arriving in T1–T3 are ignored, not queued. The requester holds its request until cyc_done.
- nRESET asserted mid-cycle: strobes release immediately (asynchronously) and the cycle is abandoned. There is no rdata_valid and rdata is reset to 8'hFF.

## Configuration

- BUS_WAIT_EN defined:
  - The nWAIT port exists.
  - nWAIT is sampled at the end of T2; nWAIT=0 moves to TW instead of T3.
  - TW repeats while nWAIT=0, then goes to T3. Strobes and DataOut hold through TW, and busy stays 1.
  - nWAIT is ignored in IDLE, T1, T3 and T4.
- BUS_WAIT_EN undefined: there is no nWAIT port and no TW state, so the cycle is always exactly 4 clocks.

## Structure

- The shared package holds:
  - the state enum (IDLE, T1, T2, T3, T4, TW);
  - constants for T-state count, address width and data width;
  - RDATA_RESET = 8'hFF.
- One sub-module is natural: bus_seq_fsm (state register plus next-state logic). Top-level strobe, address and data registers decode from its state output.

## Test plan

- Read 16'hC123 with DataBus_in=8'h5A:
  - A=16'hC123 from T1.
  - nRD low T1–T3.
  - rdata=8'h5A at N+3, rdata_valid pulse at N+4.
- Write to 16'hFF80: nWR=0 and DataOut=1 in T2–T3, nRD stays 1, cyc_done at N+4, rdata unchanged.
- Hold req_rd for 3 cycles (12 clocks): three contiguous T1–T4 sequences with no IDLE in between.
- req_rd=req_wr=1 at 16'h0100: a read cycle only, and nWR never falls.
- Test1=1 read: nRD stays 1 and rdata=8'hFF, even with DataBus_in=8'h00.
- nRESET pulsed in T2 of a write: nWR=1 and DataOut=0 immediately, state IDLE, no cyc_done. With BUS_WAIT_EN, also check that nWAIT=0 for 2 clocks stretches the cycle to 6 clocks.
